// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states and framing constants.
// Used by both the receive and transmit paths.
package uart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 7;
  localparam int DATA_W     = 8;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_e;

endpackage

// File: rtl/uart_rx_tick.sv
// Oversample tick generator: a one-clk enable every DIV cycles.
// Free-running down-counter; never used as a clock.
module uart_rx_tick #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(DIV - 1);

  generate
    if (DIV < 1) begin : g_div_chk
      $error("uart_rx_tick: DIV must be >= 1");
    end
  endgenerate

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    tick  = (cnt_q == '0);
    cnt_d = tick ? RELOAD : cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= RELOAD;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver, 16x oversampling, one-deep holding register.
// Unload strobe is edge-detected and frees the register.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_enable,
  input  logic       rx_in,
  input  logic       uld_rx_data,
  output logic [7:0] rx_data,
  output logic       rx_empty,
  output logic       rx_frame_err,
  output logic       rx_overrun
);

  localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam logic [3:0] MID  = 4'(MID_SAMPLE);
  localparam logic [3:0] LAST = 4'(uart_pkg::OVERSAMPLE - 1);

  generate
    if (OVERSAMPLE != uart_pkg::OVERSAMPLE) begin : g_os_chk
      $error("uart_receiver: OVERSAMPLE is fixed at 16");
    end
  endgenerate

  logic tick;

  uart_rx_tick #(
    .DIV (DIV)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  logic              sync1_q;
  logic              rx_s_q;
  logic              rx_s_d_q;
  logic              uld_q;
  rx_state_e         state_q, state_d;
  logic [3:0]        samp_q, samp_d;
  logic [2:0]        bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              empty_q, empty_d;
  logic              ferr_q, ferr_d;
  logic              ovr_q, ovr_d;

  logic fall;
  logic uld_rise;

  assign fall     = rx_s_d_q & ~rx_s_q;
  assign uld_rise = uld_rx_data & ~uld_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q  <= 1'b1;
      rx_s_q   <= 1'b1;
      rx_s_d_q <= 1'b1;
      uld_q    <= 1'b0;
    end else begin
      sync1_q  <= rx_in;
      rx_s_q   <= sync1_q;
      rx_s_d_q <= rx_s_q;
      uld_q    <= uld_rx_data;
    end
  end

  always_comb begin
    state_d = state_q;
    samp_d  = samp_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    empty_d = empty_q;
    ferr_d  = ferr_q;
    ovr_d   = ovr_q;

    // Unload is applied before any load in the same cycle.
    if (uld_rise) begin
      empty_d = 1'b1;
      ferr_d  = 1'b0;
      ovr_d   = 1'b0;
    end

    if (!rx_enable) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (fall) begin
            state_d = START;
            samp_d  = '0;
          end
        end
        START: begin
          if (tick) begin
            if (samp_q == MID) begin
              if (!rx_s_q) begin
                state_d = DATA;
                samp_d  = '0;
                bit_d   = '0;
              end else begin
                state_d = IDLE;
              end
            end else begin
              samp_d = samp_q + 4'd1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            samp_d = samp_q + 4'd1;
            if (samp_q == LAST) begin
              shift_d = {rx_s_q, shift_q[7:1]};
              bit_d   = bit_q + 3'd1;
              if (bit_q == 3'd7) state_d = STOP;
            end
          end
        end
        STOP: begin
          if (tick) begin
            samp_d = samp_q + 4'd1;
            if (samp_q == LAST) begin
              state_d = IDLE;
              if (rx_s_q) begin
                if (empty_d) begin
                  data_d  = shift_q;
                  empty_d = 1'b0;
                end else begin
                  ovr_d = 1'b1;
                end
              end else begin
                ferr_d = 1'b1;
              end
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      samp_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      empty_q <= 1'b1;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      samp_q  <= samp_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      empty_q <= empty_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign rx_data      = data_q;
  assign rx_empty     = empty_q;
  assign rx_frame_err = ferr_q;
  assign rx_overrun   = ovr_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver at 16 clk per bit.
// Directed plus random frames against a holding-register model.
module tb_uart_receiver;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       rx_enable = 1'b0;
  logic       rx_in = 1'b1;
  logic       uld = 1'b0;
  logic [7:0] rx_data;
  logic       rx_empty;
  logic       rx_frame_err;
  logic       rx_overrun;

  int errors = 0;
  int checks = 0;
  int lat;

  logic [7:0] m_data;
  logic       m_empty;
  logic       m_ferr;
  logic       m_ovr;

  uart_receiver #(
    .CLK_FREQ (16_000_000),
    .BAUD     (1_000_000)
  ) dut (
    .clk          (clk),
    .reset        (rst_n),
    .rx_enable    (rx_enable),
    .rx_in        (rx_in),
    .uld_rx_data  (uld),
    .rx_data      (rx_data),
    .rx_empty     (rx_empty),
    .rx_frame_err (rx_frame_err),
    .rx_overrun   (rx_overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".data"}, rx_data, m_data);
    chk({tag, ".empty"}, 8'(rx_empty), 8'(m_empty));
    chk({tag, ".ferr"}, 8'(rx_frame_err), 8'(m_ferr));
    chk({tag, ".ovr"}, 8'(rx_overrun), 8'(m_ovr));
  endtask

  task automatic m_rst();
    m_data  = 8'h00;
    m_empty = 1'b1;
    m_ferr  = 1'b0;
    m_ovr   = 1'b0;
  endtask

  task automatic m_unload();
    m_empty = 1'b1;
    m_ferr  = 1'b0;
    m_ovr   = 1'b0;
  endtask

  task automatic m_frame(input logic [7:0] b, input logic ok);
    if (!ok) m_ferr = 1'b1;
    else if (m_empty) begin
      m_data  = b;
      m_empty = 1'b0;
    end else m_ovr = 1'b1;
  endtask

  // nbits < 8 aborts after that many data bits, line left as driven.
  task automatic send(input logic [7:0] b, input logic stop,
                      input int nbits, input int uld_at);
    logic [9:0] fr;
    logic       emp0;
    int         total;
    fr    = {stop, b, 1'b0};
    total = (nbits >= 8) ? 160 : 16 * (nbits + 1);
    lat   = -1;
    @(negedge clk);
    emp0  = rx_empty;
    rx_in = 1'b0;
    for (int k = 1; k <= total; k++) begin
      @(negedge clk);
      if (k == uld_at) uld = 1'b1;
      if (k == uld_at + 2) uld = 1'b0;
      if (lat < 0 && emp0 && !rx_empty) lat = k;
      if (k % 16 == 0 && k < total) rx_in = fr[k/16];
    end
  endtask

  task automatic unload(input string tag);
    @(negedge clk);
    uld = 1'b1;
    @(negedge clk);
    m_unload();
    chk({tag, ".uld_empty"}, 8'(rx_empty), 8'(m_empty));
    uld = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] b;
    logic       ok;
    m_rst();
    #2 rst_n = 1'b0;
    #1 chk_all("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    rx_enable = 1'b1;
    repeat (4) @(negedge clk);

    send(8'h6E, 1'b1, 8, -1);
    m_frame(8'h6E, 1'b1);
    chk("t2.latency", 8'(lat), 8'd155);
    chk_all("t2");
    unload("t2");
    chk_all("t2u");

    send(8'h55, 1'b1, 8, -1);
    m_frame(8'h55, 1'b1);
    send(8'hAA, 1'b1, 8, -1);
    m_frame(8'hAA, 1'b1);
    repeat (4) @(negedge clk);
    chk_all("t3");
    unload("t3");
    chk_all("t3u");

    send(8'hFF, 1'b0, 8, -1);
    m_frame(8'hFF, 1'b0);
    repeat (640) @(negedge clk);
    chk_all("t4");
    rx_in = 1'b1;
    repeat (20) @(negedge clk);
    chk_all("t4b");
    unload("t4");

    @(negedge clk);
    rx_in = 1'b0;
    repeat (5) @(negedge clk);
    rx_in = 1'b1;
    repeat (40) @(negedge clk);
    chk_all("t5g");

    send(8'hC3, 1'b1, 3, -1);
    rx_enable = 1'b0;
    rx_in = 1'b1;
    repeat (30) @(negedge clk);
    rx_enable = 1'b1;
    repeat (5) @(negedge clk);
    chk_all("t5d");
    send(8'h3C, 1'b1, 8, -1);
    m_frame(8'h3C, 1'b1);
    repeat (4) @(negedge clk);
    chk_all("t5c");
    unload("t5");

    send(8'h18, 1'b1, 8, -1);
    m_frame(8'h18, 1'b1);
    chk_all("t6a");
    send(8'h81, 1'b1, 8, 154);
    m_unload();
    m_frame(8'h81, 1'b1);
    repeat (4) @(negedge clk);
    chk_all("t6");
    unload("t6");

    for (int i = 0; i < 8; i++) begin
      b  = 8'($urandom);
      ok = ($urandom_range(0, 3) != 0);
      send(b, ok, 8, -1);
      m_frame(b, ok);
      rx_in = 1'b1;
      repeat (8) @(negedge clk);
      chk_all("rnd");
      if ($urandom_range(0, 1) == 1) unload("rnd");
    end

    send(8'h3D, 1'b1, 8, -1);
    m_frame(8'h3D, 1'b1);
    send(8'hA5, 1'b1, 4, -1);
    rst_n = 1'b0;
    #1;
    m_rst();
    chk_all("t1r");
    rx_in = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    send(8'hA5, 1'b1, 8, -1);
    m_frame(8'hA5, 1'b1);
    repeat (4) @(negedge clk);
    chk_all("t1");
    unload("t1");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
